// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl -- MEM-stage sequencing controller.
//
// Purpose:
//   Converts the EX/MEM register's memread/memwrite/result/data outputs into a
//   req/ack transaction on a multi-cycle data memory. It holds the upstream
//   pipeline (stall_o, front_stall_o) and bubbles MEM/WB while an access is
//   outstanding. It also detects load-use hazards, so every pipeline-hold
//   decision comes from this one block.
//
// Optional feature (macro MEM_TIMEOUT_EN):
//   Defined     : an 8-bit counter aborts an ACCESS that sees no ack for
//                 TIMEOUT_CYCLES cycles. err_o is set (sticky) and reads
//                 return ERR_DATA.
//   Not defined : ACCESS waits indefinitely for ack. err_o is tied 0.
//
// Ports:
//   clk_i, rst_i               clock; synchronous active-high reset
//   memread_i, memwrite_i      memory op request from EX/MEM
//   addr_i, wdata_i            access address / store data from EX/MEM
//   mem_req_o, mem_we_o        memory request and direction (1 = write)
//   mem_addr_o, mem_wdata_o    registered access address / store data
//   mem_ack_i, mem_rdata_i     memory completion strobe and read data
//   rdata_o                    registered load data to MEM/WB
//   stall_o                    MEM-stage hold to EX/MEM
//   memwb_bubble_o             MEM/WB loads zero control bits
//   idex_memread_i, idex_rt_i  load in ID/EX and its destination register
//   ifid_rs_i, ifid_rt_i       source registers of the instruction in IF/ID
//   front_stall_o              hold for PC and IF/ID
//   idex_bubble_o              ID/EX loads zero control bits
//   err_o                      sticky access-timeout flag
module mem_access_ctrl #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        memwb_bubble_o,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  output logic        front_stall_o,
  output logic        idex_bubble_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Count value on which an un-acked ACCESS is aborted.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t state_reg, state_next;
  logic   mem_op;
  logic   timeout_hit;
  logic   hazard;

  assign mem_op = memread_i | memwrite_i;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_reg;

  // An ack in the final cycle wins over the timeout.
  assign timeout_hit = (state_reg == ACCESS) && !mem_ack_i && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_reg <= 8'd0;
      err_o       <= 1'b0;
    end else begin
      if (state_reg == IDLE && mem_op)
        tmo_cnt_reg <= 8'd0;
      else if (state_reg == ACCESS && !mem_ack_i && !timeout_hit)
        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
      if (timeout_hit)
        err_o <= 1'b1;
    end
  end
`else
  logic unused_tmo_cfg;

  assign unused_tmo_cfg = ^TMO_LAST;
  assign timeout_hit    = 1'b0;
  assign err_o          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic. DONE always returns to IDLE so the held instruction is
  // never reissued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mem_op) state_next = ACCESS;
      ACCESS:  if (mem_ack_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request/datapath registers. Request fields are captured once on entry to
  // ACCESS and held stable until completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'd0;
      mem_wdata_o <= 32'd0;
      rdata_o     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_op) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= memwrite_i;  // read+write together counts as a write
            mem_addr_o  <= addr_i;
            mem_wdata_o <= wdata_i;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
          end else if (timeout_hit) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) rdata_o <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Pipeline hold decisions. stall_o is low in DONE so EX/MEM advances exactly
  // once and MEM/WB captures rdata_o.
  assign stall_o        = ((state_reg == IDLE) && mem_op) || (state_reg == ACCESS);
  assign memwb_bubble_o = stall_o;

  assign hazard = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

  assign front_stall_o = stall_o | hazard;
  // While the MEM stage holds, ID/EX just holds as well; no bubble is needed.
  assign idex_bubble_o = hazard & ~stall_o;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN  = 1'b1;
  localparam int DUT_TMO = 4;
`else
  localparam bit TMO_EN  = 1'b0;
  localparam int DUT_TMO = 255;
`endif
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        memread_i = 1'b0, memwrite_i = 1'b0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] rdata_o;
  logic        stall_o, memwb_bubble_o;
  logic        idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = '0, ifid_rs_i = '0, ifid_rt_i = '0;
  logic        front_stall_o, idex_bubble_o, err_o;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(DUT_TMO), .ERR_DATA(ERR_DATA)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .memwb_bubble_o(memwb_bubble_o),
    .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .front_stall_o(front_stall_o), .idex_bubble_o(idex_bubble_o),
    .err_o(err_o)
  );

  // Expected outcome of one memory instruction.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;     // rdata_o after completion
    int          stall;  // number of stall_o cycles
    bit          err;
  } exp_t;

  // Memory responder script: ack after wt wait cycles.
  typedef struct {
    int          wt;
    logic [31:0] rdata;
  } resp_t;

  exp_t        exp_q[$];
  resp_t       resp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          stall_cnt = 0;
  bit          manual = 1'b0;
  bit          resp_busy = 1'b0;
  int          resp_cnt = 0;
  resp_t       resp_cur;
  logic [31:0] model_rd = '0;
  bit          model_err = 1'b0;
  int          txn_id = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Issue one memory instruction from EX/MEM and hold it until it completes.
  // Called just after a posedge.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int wt, input logic [31:0] rdata);
    exp_t  e;
    resp_t r;
    bit    tmo;
    int    d0;
    tmo     = TMO_EN && (wt >= DUT_TMO);
    e.we    = wr;
    e.addr  = a;
    e.wdata = d;
    e.stall = tmo ? (1 + DUT_TMO) : (2 + wt);
    if (!wr) model_rd = tmo ? ERR_DATA : rdata;
    if (tmo) model_err = 1'b1;
    e.rd    = model_rd;
    e.err   = model_err;
    r.wt    = wt;
    r.rdata = rdata;
    exp_q.push_back(e);
    resp_q.push_back(r);
    txn_id++;
    $display("txn %0d: %s addr=%h wdata=%h wait=%0d rdata=%h -> exp rdata_o=%h stall=%0d",
             txn_id, wr ? "WR" : "RD", a, d, wt, rdata, e.rd, e.stall);
    memread_i  = rd;
    memwrite_i = wr;
    addr_i     = a;
    wdata_i    = d;
    d0 = done_cnt;
    for (int i = 0; i < 60 && done_cnt == d0; i++) @(posedge clk);
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL txn_timeout: got no completion expected completion within 60 cycles");
      exp_q.delete();
    end
    #1;
    memread_i  = 1'b0;
    memwrite_i = 1'b0;
    addr_i     = $urandom;
    wdata_i    = $urandom;
  endtask

  // Hazard-unit inputs are randomized every cycle, independent of memory ops.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      idex_memread_i = 1'($urandom_range(0, 1));
      idex_rt_i      = 5'($urandom_range(0, 3));
      ifid_rs_i      = 5'($urandom_range(0, 3));
      ifid_rt_i      = 5'($urandom_range(0, 3));
    end
  end

  // Memory model: acks after the scripted wait; sprays spurious acks when idle.
  always @(negedge clk) begin
    if (manual) begin
      resp_busy = 1'b0;
    end else if (rst_i) begin
      resp_busy = 1'b0;
      mem_ack_i = 1'b0;
    end else if (mem_req_o) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        resp_cnt  = 0;
        if (resp_q.size() > 0) resp_cur = resp_q[0];
        else begin
          resp_cur.wt    = 1000;
          resp_cur.rdata = '0;
        end
      end
      if (resp_cnt == resp_cur.wt) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = resp_cur.rdata;
      end else begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
      end
      resp_cnt++;
    end else begin
      if (resp_busy) begin
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        resp_busy = 1'b0;
      end
      mem_ack_i   = ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    bit   hz;
    exp_t e;
    if (rst_i || manual) begin
      stall_cnt = 0;
    end else begin
      hz = idex_memread_i && (idex_rt_i != 0) &&
           ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
      chk("memwb_bubble", 32'(memwb_bubble_o), 32'(stall_o));
      chk("front_stall", 32'(front_stall_o), 32'(stall_o | hz));
      chk("idex_bubble", 32'(idex_bubble_o), 32'(hz & ~stall_o));
      if (stall_o) begin
        stall_cnt++;
        if (exp_q.size() == 0) begin
          chk("stall_without_op", 32'(stall_o), 32'd0);
        end else if (mem_req_o) begin
          chk("mem_we", 32'(mem_we_o), 32'(exp_q[0].we));
          chk("mem_addr", mem_addr_o, exp_q[0].addr);
          chk("mem_wdata", mem_wdata_o, exp_q[0].wdata);
        end
      end else if (stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          chk("done_without_op", 32'(stall_cnt), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
          chk("rdata_o", rdata_o, e.rd);
          chk("req_low_in_done", 32'(mem_req_o), 32'd0);
          chk("err_o", 32'(err_o), 32'(e.err));
        end
        done_cnt++;
        stall_cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Directed: load with immediate ack, store with 3 wait cycles.
    issue(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h12345678);
    issue(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 3, 32'h0BADF00D);
    // Back-to-back with read+write treated as write.
    issue(1'b1, 1'b1, 32'h80, 32'h11112222, 1, 32'h33334444);

    // Randomized mix of loads, stores, combined and idle gaps.
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      if (kind == 3) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end else begin
        issue(kind != 1, kind != 0, $urandom, $urandom, $urandom_range(0, 3), $urandom);
      end
    end

`ifdef MEM_TIMEOUT_EN
    // Load that never gets an ack: aborts after DUT_TMO ACCESS cycles.
    issue(1'b1, 1'b0, 32'h200, 32'h0, 99, 32'h0);
`endif

    // Reset in the middle of an ACCESS, followed by a late ack.
    manual     = 1'b1;
    mem_ack_i  = 1'b0;
    resp_q.delete();
    memread_i  = 1'b1;
    addr_i     = 32'h300;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_access_req", 32'(mem_req_o), 32'd1);
    @(posedge clk);
    #1;
    rst_i     = 1'b1;
    memread_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i       = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h55AA55AA;
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_req", 32'(mem_req_o), 32'd0);
      chk("post_rst_stall", 32'(stall_o), 32'd0);
      chk("post_rst_rdata", rdata_o, 32'd0);
      chk("post_rst_err", 32'(err_o), 32'd0);
    end
    $display("reset mid-access: late ack ignored");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencing controller for the MEM stage of the 5-stage pipeline.
- Turns the EX/MEM register's memread/memwrite/result/data outputs into a req/ack transaction to a multi-cycle data memory.
- Drives the stall input of PC, IF/ID, ID/EX and EX/MEM, and bubbles MEM/WB while an access is outstanding.
- Also performs load-use hazard detection, so one block owns every pipeline-hold decision.

Parameters:
- TIMEOUT_CYCLES, 255, ACCESS cycles without ack before abort (used only with MEM_TIMEOUT_EN).
- ERR_DATA, 32'hDEADBEEF, rdata_o value returned on abort.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, synchronous, active-high.
- memread_i  in  1  from EX/MEM memread_o.
- memwrite_i  in  1  from EX/MEM memwrite_o.
- addr_i  in  32  from EX/MEM result_o.
- wdata_i  in  32  from EX/MEM data_o.
- mem_req_o  out  1  request to data memory.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  32  access address.
- mem_wdata_o  out  32  write data.
- mem_ack_i  in  1  memory completion strobe.
- mem_rdata_i  in  32  read data, valid with mem_ack_i.
- rdata_o  out  32  registered load data to MEM/WB.
- stall_o  out  1  to EX/MEM stall_i (MEM-stage hold).
- memwb_bubble_o  out  1  MEM/WB loads zero control bits.
- idex_memread_i  in  1  ID/EX memread.
- idex_rt_i  in  5  ID/EX destination of the load.
- ifid_rs_i  in  5  IF/ID source register rs.
- ifid_rt_i  in  5  IF/ID source register rt.
- front_stall_o  out  1  to PC and IF/ID hold.
- idex_bubble_o  out  1  ID/EX loads zero control bits.
- err_o  out  1  sticky access-timeout flag.

Behaviour:
- Reset: all registered outputs and state are cleared on rst_i high at a posedge.
  - state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata_o=0, err_o=0, timeout counter=0.
  - Combinational outputs follow from state=IDLE.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: if memread_i|memwrite_i, go to ACCESS. On that edge, latch mem_addr_o<=addr_i, mem_wdata_o<=wdata_i, mem_we_o<=memwrite_i, mem_req_o<=1.
  - ACCESS: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until mem_ack_i is sampled high. On ack: mem_req_o<=0, rdata_o<=mem_rdata_i (reads only; writes leave rdata_o unchanged), go to DONE.
  - DONE: unconditionally go to IDLE. Inputs are ignored in this state, so the same instruction is never reissued.
- Combinational stall_o = (state==IDLE & (memread_i|memwrite_i)) | (state==ACCESS).
  - stall_o is 0 in DONE, so EX/MEM advances exactly once and MEM/WB captures rdata_o.
- memwb_bubble_o = stall_o.
- Latency: an ack in the first ACCESS cycle gives a minimum of 2 stall cycles, then DONE. Each additional ack-wait cycle adds one stall cycle.
- memread_i and memwrite_i both high: treated as a write.
- mem_ack_i while in IDLE or DONE is ignored.
- Load-use hazard: hz = idex_memread_i & (idex_rt_i!=0) & (idex_rt_i==ifid_rs_i | idex_rt_i==ifid_rt_i).
  - front_stall_o = stall_o | hz.
  - idex_bubble_o = hz & ~stall_o. While stall_o is high, ID/EX simply holds; no bubble is injected.
- Reset mid-access: mem_req_o drops at that edge and the FSM returns to IDLE. A late ack after reset is ignored.
- Back-to-back memory instructions: DONE→IDLE, then the new op is detected in IDLE in the following cycle.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter, sized for TIMEOUT_CYCLES, runs in ACCESS and clears on entry to ACCESS.
  - When the count reaches TIMEOUT_CYCLES with no ack: mem_req_o<=0, err_o<=1 (sticky until reset), rdata_o<=ERR_DATA on reads, go to DONE.
- Not defined: no counter; ACCESS waits indefinitely for ack; err_o is tied 0.

Test Plan:
- Reset is applied with req pending → next cycle mem_req_o=0, stall_o=0, rdata_o=0, err_o=0.
- Load addr_i=0x100, ack in first ACCESS cycle with rdata=0x12345678 → stall_o high 2 cycles, mem_we_o=0, then DONE with stall_o=0 and rdata_o=0x12345678.
- Store addr_i=0x40, wdata_i=0xCAFEF00D, ack after 3 wait cycles → addr and wdata stable throughout, stall_o high 5 cycles, mem_we_o=1, rdata_o unchanged.
- Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8, no mem op → front_stall_o=1, idex_bubble_o=1, stall_o=0. With idex_rt_i=0 → all 0.
- rst_i asserted in ACCESS, then ack pulse arrives → FSM stays IDLE, rdata_o=0, no DONE cycle.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack → after 4 ACCESS cycles err_o=1, rdata_o=0xDEADBEEF, stall_o releases in DONE.
